// File: rtl/receiver_controller.sv
// Receive-side frame parser: hunts for 52 0C 01 D0..D7 CS 9A, verifies it and commits
// the payload, with a button-stepped preview of one committed byte.
module receiver_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        s3,
  input  logic        s0,
  input  logic        btn_en,
  output logic [63:0] data_out,
  output logic [7:0]  preview_data,
  output logic [2:0]  preview_index,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [7:0]  frame_count
);

  // state | meaning
  // HUNT  | waiting for 0x52 start byte
  // LEN   | expecting 0x0C length
  // FUNC  | expecting 0x01 function code
  // DATA  | collecting 8 payload bytes
  // CSUM  | expecting checksum
  // TAIL  | expecting 0x9A tail
  typedef enum logic [2:0] {HUNT, LEN, FUNC, DATA, CSUM, TAIL} state_t;

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] SOF_B  = 8'h52;
  localparam logic [7:0] LEN_B  = 8'h0C;
  localparam logic [7:0] FUNC_B = 8'h01;
  localparam logic [7:0] TAIL_B = 8'h9A;
  localparam logic [7:0] CS_B   = 8'h06;

  state_t          state, state_next;
  logic [7:0]      shadow [8];
  logic [7:0]      committed [8];
  logic [7:0]      sum;
  logic [7:0]      cs_expect;
  logic [2:0]      idx;
  logic [CW-1:0]   idle_cnt;
  logic            s3_prev, s0_prev;
  logic            ok_next, err_next, store_byte, start_data, commit, timeout;
  logic [1:0]      code_next;

  assign cs_expect = CS_B - sum;
  assign timeout   = (state != HUNT) && !rx_valid && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ok_next    = 1'b0;
    err_next   = 1'b0;
    code_next  = 2'b00;
    store_byte = 1'b0;
    start_data = 1'b0;
    commit     = 1'b0;
    if (rx_valid) begin
      case (state)
        HUNT: if (rx_data == SOF_B) state_next = LEN;
        LEN: begin
          if (rx_data == LEN_B) state_next = FUNC;
          else if (rx_data != SOF_B) begin
            err_next = 1'b1; code_next = 2'b01; state_next = HUNT;
          end
        end
        FUNC: begin
          if (rx_data == FUNC_B) begin
            state_next = DATA; start_data = 1'b1;
          end else if (rx_data == SOF_B) state_next = LEN;
          else begin
            err_next = 1'b1; code_next = 2'b01; state_next = HUNT;
          end
        end
        DATA: begin
          store_byte = 1'b1;
          if (idx == 3'd7) state_next = CSUM;
        end
        CSUM: begin
          if (rx_data == cs_expect) state_next = TAIL;
          else begin
            err_next = 1'b1; code_next = 2'b10; state_next = HUNT;
          end
        end
        TAIL: begin
          state_next = HUNT;
          if (rx_data == TAIL_B) begin
            commit = 1'b1; ok_next = 1'b1;
          end else begin
            err_next = 1'b1; code_next = 2'b11;
          end
        end
        default: state_next = HUNT;
      endcase
    end else if (timeout) begin
      err_next = 1'b1; code_next = 2'b00; state_next = HUNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i]    <= '0;
        committed[i] <= '0;
      end
      sum         <= '0;
      idx         <= '0;
      idle_cnt    <= '0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'b00;
      frame_count <= '0;
    end else begin
      frame_ok  <= ok_next;
      frame_err <= err_next;
      err_code  <= code_next;
      idle_cnt  <= (rx_valid || state == HUNT || timeout) ? '0 : idle_cnt + CW'(1);
      if (start_data) begin
        idx <= '0;
        sum <= '0;
      end
      if (store_byte) begin
        shadow[idx] <= rx_data;
        sum         <= sum + rx_data;
        idx         <= idx + 3'd1;
      end
      if (commit) begin
        for (int i = 0; i < 8; i++) committed[i] <= shadow[i];
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  // Previous-value registers only advance while sampling is enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_prev       <= 1'b0;
      s0_prev       <= 1'b0;
      preview_index <= '0;
    end else if (btn_en) begin
      s3_prev <= s3;
      s0_prev <= s0;
      if (s3 && !s3_prev)      preview_index <= preview_index + 3'd1;
      else if (s0 && !s0_prev) preview_index <= preview_index - 3'd1;
    end
  end

  assign data_out = {committed[0], committed[1], committed[2], committed[3],
                     committed[4], committed[5], committed[6], committed[7]};
  assign preview_data = committed[preview_index];

endmodule

// File: tb/tb_receiver_controller.sv
// Bench for receiver_controller: directed frames with literal expectations plus a randomized
// stream, all checked every cycle against a frame-position model built on a byte queue.
module tb_receiver_controller;
  localparam int unsigned T = 16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0, s3 = 1'b0, s0 = 1'b0, btn_en = 1'b0;
  logic [63:0] data_out;
  logic [7:0]  preview_data, frame_count;
  logic [2:0]  preview_index;
  logic        frame_ok, frame_err;
  logic [1:0]  err_code;

  int errors = 0, checks = 0;
  int n_ok = 0, n_err = 0, ok0, err0;
  logic [1:0] last_code = 2'b00;
  bit checking = 0, rand_btn = 0;

  always #5 clk = ~clk;

  receiver_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .s3(s3), .s0(s0), .btn_en(btn_en), .data_out(data_out),
    .preview_data(preview_data), .preview_index(preview_index),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .frame_count(frame_count));

  // Model: partial frame held as a byte queue, its length is the parse position
  logic [7:0] mq[$];
  logic [7:0] m_data[8];
  logic       m_ok, m_err, m_p3, m_p0;
  logic [1:0] m_code;
  logic [7:0] m_count, mb;
  logic [2:0] m_idx;
  int         m_idle, msum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      for (int i = 0; i < 8; i++) m_data[i] = 8'h00;
      m_ok = 0; m_err = 0; m_code = 2'b00; m_count = 8'h00;
      m_idx = 3'd0; m_p3 = 0; m_p0 = 0; m_idle = 0;
    end else begin
      m_ok = 0; m_err = 0; m_code = 2'b00;
      if (rx_valid) begin
        m_idle = 0;
        mb = rx_data;
        case (mq.size())
          0: if (mb == 8'h52) mq.push_back(mb);
          1: if (mb == 8'h0C) mq.push_back(mb);
             else if (mb != 8'h52) begin m_err = 1; m_code = 2'b01; mq.delete(); end
          2: if (mb == 8'h01) mq.push_back(mb);
             else if (mb == 8'h52) begin mq.delete(); mq.push_back(mb); end
             else begin m_err = 1; m_code = 2'b01; mq.delete(); end
          11: begin
            msum = 0;
            for (int i = 3; i < 11; i++) msum += int'(mq[i]);
            if (mb == 8'(6 - msum)) mq.push_back(mb);
            else begin m_err = 1; m_code = 2'b10; mq.delete(); end
          end
          12: begin
            if (mb == 8'h9A) begin
              for (int i = 0; i < 8; i++) m_data[i] = mq[3+i];
              m_ok = 1; m_count = m_count + 8'd1;
            end else begin m_err = 1; m_code = 2'b11; end
            mq.delete();
          end
          default: mq.push_back(mb);
        endcase
      end else if (mq.size() != 0) begin
        m_idle++;
        if (m_idle == int'(T)) begin
          m_err = 1; m_code = 2'b00; mq.delete(); m_idle = 0;
        end
      end
      if (btn_en) begin
        if (s3 && !m_p3)      m_idx = m_idx + 3'd1;
        else if (s0 && !m_p0) m_idx = m_idx - 3'd1;
        m_p3 = s3; m_p0 = s0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("data_out", data_out, {m_data[0], m_data[1], m_data[2], m_data[3],
                                 m_data[4], m_data[5], m_data[6], m_data[7]});
      chk("preview_data", {56'h0, preview_data}, {56'h0, m_data[m_idx]});
      chk("preview_index", {61'h0, preview_index}, {61'h0, m_idx});
      chk("frame_ok", {63'h0, frame_ok}, {63'h0, m_ok});
      chk("frame_err", {63'h0, frame_err}, {63'h0, m_err});
      chk("ok_err_excl", {63'h0, frame_ok & frame_err}, 64'h0);
      if (m_err) chk("err_code", {62'h0, err_code}, {62'h0, m_code});
      chk("frame_count", {56'h0, frame_count}, {56'h0, m_count});
      if (frame_ok) n_ok++;
      if (frame_err) begin n_err++; last_code = err_code; end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (rand_btn) begin
      btn_en = 1'($urandom_range(0, 1));
      s3 = ($urandom_range(0, 3) == 0);
      s0 = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] csum(input logic [63:0] p);
    int t = 0;
    for (int i = 0; i < 8; i++) t += int'(p[63-8*i -: 8]);
    return 8'(6 - t);
  endfunction

  task automatic send_frame(input logic [63:0] p, input logic [7:0] cs, input logic [7:0] tail);
    send(8'h52); send(8'h0C); send(8'h01);
    for (int i = 0; i < 8; i++) send(p[63-8*i -: 8]);
    send(cs); send(tail);
  endtask

  task automatic mark();
    ok0 = n_ok; err0 = n_err;
  endtask

  logic [7:0]  q[$];
  logic [63:0] rp;
  logic [7:0]  rc, bb;
  int          kind;

  initial begin
    step(); checking = 1;
    idle(2);
    rst_n = 1'b1;
    chk("rst_data_out", data_out, 64'h0);
    chk("rst_count", {56'h0, frame_count}, 64'h0);
    chk("rst_preview", {56'h0, preview_data}, 64'h0);
    chk("rst_index", {61'h0, preview_index}, 64'h0);
    idle(2);

    mark();
    send_frame(64'h0102030405060708, 8'hE2, 8'h9A); idle(2);
    chk("nom_ok", n_ok - ok0, 1);
    chk("nom_data", data_out, 64'h0102030405060708);
    chk("nom_count", {56'h0, frame_count}, 64'd1);
    chk("nom_preview", {56'h0, preview_data}, 64'h01);

    btn_en = 1; s0 = 1; step(); s0 = 0; step();
    chk("btn_s0_index", {61'h0, preview_index}, 64'd7);
    chk("btn_s0_preview", {56'h0, preview_data}, 64'h08);
    s3 = 1;
    repeat (3) begin btn_en = 1; step(); btn_en = 0; step(); end
    s3 = 0; btn_en = 1; step();
    chk("btn_s3_held", {61'h0, preview_index}, 64'd0);
    s3 = 1; s0 = 1; step(); s3 = 0; s0 = 0; step();
    chk("btn_both", {61'h0, preview_index}, 64'd1);
    btn_en = 0; s3 = 1; step(); s3 = 0; s0 = 1; step(); s0 = 0; step();
    chk("btn_disabled", {61'h0, preview_index}, 64'd1);

    mark();
    send_frame(64'h0, 8'h06, 8'h9A); idle(2);
    chk("zero_ok", n_ok - ok0, 1);
    chk("zero_data", data_out, 64'h0);
    mark();
    send_frame(64'h0, 8'h07, 8'h9A); idle(2);
    chk("cs_err", n_err - err0, 1);
    chk("cs_code", {62'h0, last_code}, 64'd2);
    chk("cs_count", {56'h0, frame_count}, 64'd2);

    mark();
    send(8'h11); send(8'h52); send_frame(64'h0, 8'h06, 8'h9A); idle(2);
    chk("resync_ok", n_ok - ok0, 1);
    chk("resync_noerr", n_err - err0, 0);

    mark();
    send(8'h52); send(8'h0D); idle(2);
    chk("len_err", n_err - err0, 1);
    chk("len_code", {62'h0, last_code}, 64'd1);

    mark();
    send_frame(64'h0102030405060708, 8'hE2, 8'h9B); idle(2);
    chk("tail_code", {62'h0, last_code}, 64'd3);
    chk("tail_data", data_out, 64'h0);

    mark();
    send(8'h52); send(8'h0C); send(8'h01); send(8'hAA); idle(18);
    chk("to_err", n_err - err0, 1);
    chk("to_code", {62'h0, last_code}, 64'd0);

    mark();
    send(8'h52); send(8'h0C); send(8'h01); send(8'hAA); idle(15);
    for (int i = 1; i < 8; i++) send(8'(i));
    send(8'h40); send(8'h9A); idle(2);
    chk("gap15_ok", n_ok - ok0, 1);
    chk("gap15_noerr", n_err - err0, 0);
    chk("gap15_data", data_out, 64'hAA01020304050607);

    send(8'h52); send(8'h0C); send(8'h01);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    rst_n = 1'b0; step(); step();
    rst_n = 1'b1; step();
    chk("mid_rst_data", data_out, 64'h0);
    chk("mid_rst_count", {56'h0, frame_count}, 64'h0);
    chk("mid_rst_index", {61'h0, preview_index}, 64'h0);
    chk("mid_rst_preview", {56'h0, preview_data}, 64'h0);
    send_frame(64'h0102030405060708, 8'hE2, 8'h9A); idle(2);
    chk("post_rst_count", {56'h0, frame_count}, 64'd1);

    repeat (255) begin
      rp = {$urandom, $urandom};
      send_frame(rp, csum(rp), 8'h9A);
    end
    idle(2);
    chk("count_wrap", {56'h0, frame_count}, 64'd0);

    rand_btn = 1;
    repeat (120) begin
      rp = {$urandom, $urandom};
      rc = csum(rp);
      q.delete();
      q.push_back(8'h52); q.push_back(8'h0C); q.push_back(8'h01);
      for (int i = 0; i < 8; i++) q.push_back(rp[63-8*i -: 8]);
      q.push_back(rc); q.push_back(8'h9A);
      kind = $urandom_range(0, 8);
      case (kind)
        3: begin bb = 8'($urandom); if (bb == 8'h0C || bb == 8'h52) bb = 8'h0D; q[1] = bb; end
        4: begin bb = 8'($urandom); if (bb == 8'h01 || bb == 8'h52) bb = 8'h02; q[2] = bb; end
        5: q[11] = rc + 8'd1;
        6: q[12] = 8'h9B;
        7: q.push_front(8'($urandom));
        8: q.push_front(8'h52);
        default: ;
      endcase
      foreach (q[i]) begin
        if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 20));
        send(q[i]);
      end
      idle($urandom_range(0, 2));
    end
    rand_btn = 0; btn_en = 0; s3 = 0; s0 = 0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/receiver_controller.md
# receiver_controller

Frame-level receive controller for the UART link: the receiving end of the 13-byte frame that the sender side emits. It consumes bytes from the UART receiver, hunts for and parses the frame, and verifies length, function code, checksum and tail. On a good frame it commits the 8 payload bytes to visible registers. A button-driven index selects one committed byte for the preview display.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1_000_000: maximum idle cycles between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1: system clock.
- rst_n  in  1: reset, asynchronous, active-low.
- rx_data  in  8: received byte from the UART receiver.
- rx_valid  in  1: one-cycle strobe, rx_data valid. Back-to-back strobes are allowed.
- s3  in  1: next-byte button; preview index +1.
- s0  in  1: previous-byte button; preview index −1.
- btn_en  in  1: button sample enable. Edge detection and index updates happen only when it is high.
- data_out  out  64: committed payload, byte 0 in [63:56] … byte 7 in [7:0].
- preview_data  out  8: committed byte at preview_index.
- preview_index  out  3: selected byte index.
- frame_ok  out  1: one-cycle pulse, good frame committed.
- frame_err  out  1: one-cycle pulse, frame aborted.
- err_code  out  2: valid only while frame_err is high. 00 timeout, 01 length/function mismatch, 10 checksum mismatch, 11 tail mismatch.
- frame_count  out  8: count of good frames, wraps 255→0.

## Operation
- Frame layout, in order: 0x52, 0x0C, 0x01, D0..D7, CS, 0x9A.
- Checksum: CS = ~(0x52+0x0C+0x01+0x9A+D0+…+D7) mod 256, which equals (0x06 − ΣD) mod 256.
- FSM states: HUNT, LEN, FUNC, DATA, CSUM, TAIL. Transitions occur only on rx_valid, except for timeout.
  - HUNT: 0x52 → LEN. Any other byte is dropped silently, with no error.
  - LEN: 0x0C → FUNC. 0x52 → stay in LEN (resync), with no error. Any other byte → frame_err with code 01, then HUNT.
  - FUNC: 0x01 → DATA with byte index 0. 0x52 → LEN (resync), with no error. Any other byte → frame_err with code 01, then HUNT.
  - DATA: store the byte in shadow buffer [index] and add it to an 8-bit running sum. Index 7 → CSUM. Payload bytes are never interpreted as markers.
  - CSUM: byte equals (0x06 − sum) mod 256 → TAIL. Otherwise frame_err with code 10, then HUNT. The following tail byte is then ignored in HUNT.
  - TAIL: 0x9A → copy the shadow buffer to data_out, pulse frame_ok, increment frame_count, go to HUNT. Any other byte → frame_err with code 11, then HUNT, and committed data is unchanged.
- Committed data changes only on frame_ok. Aborted frames never alter data_out.
- Timeout:
  - The idle counter clears on every rx_valid and counts only outside HUNT.
  - When TIMEOUT_CYCLES consecutive cycles pass with no rx_valid, raise frame_err with code 00 and go to HUNT.
  - If rx_valid arrives on the cycle the limit would be reached, the byte wins and no timeout occurs.
- Buttons:
  - Each of s3 and s0 has a previous-value register, updated only when btn_en is high.
  - A rising edge is s=1 while prev=0, with btn_en high.
  - s3 edge: index+1, wrapping 7→0. s0 edge: index−1, wrapping 0→7.
  - Simultaneous s3 and s0 edges: s3 wins.
- preview_data = data_out byte[preview_index], as a combinational read of registers.

## Timing
- Reset values: state HUNT, data_out 0, preview_index 0, preview_data 0x00, frame_ok 0, frame_err 0, err_code 00, frame_count 0, shadow buffer, sum, idle counter and button prev registers all 0.
- A reset mid-frame discards the partial frame immediately.
- Latency:
  - frame_ok, data_out, frame_count and the new preview_data are visible the cycle after the tail's rx_valid edge.
  - frame_err and err_code are visible the cycle after the offending byte.
  - A timeout frame_err is visible on the cycle after the limit is reached.
- frame_ok and frame_err are never high together, and each is exactly 1 cycle wide.
- Full-rate input (rx_valid every cycle) is handled with no byte loss. A 0x52 arriving the cycle right after an error pulse is accepted as a new frame start.
- Button response: preview_index updates on the cycle after the qualifying btn_en edge. preview_data follows in the same cycle.

## Test plan
- Nominal frame: 52 0C 01 01 02 03 04 05 06 07 08 E2 9A → one frame_ok pulse, data_out = 0x0102030405060708, frame_count = 1, preview_data = 0x01.
- All-zero payload with CS = 0x06 accepted. Then the same frame with CS = 0x07 → frame_err with code 10, data_out unchanged, frame_count unchanged.
- Garbage plus resync: 11 52 52 0C 01, zero payload, 06 9A → frame_ok, no frame_err. Separately, 52 0D → frame_err with code 01. Separately, a good frame up to CS followed by 9B → frame_err with code 11.
- Timeout with TIMEOUT_CYCLES=16: send 52 0C 01 AA, then idle 16 cycles → frame_err with code 00. A gap of exactly 15 cycles followed by the remaining bytes completes with frame_ok.
- Buttons after a good frame of 01..08:
  - s0 pulse with btn_en=1 → index 7, preview 0x08.
  - s3 held for 3 btn_en pulses → one increment only, index 0.
  - s3 and s0 rising together → index 1.
  - Edges while btn_en=0 are ignored.
- rst_n asserted after D3 of a frame, then released → all outputs at reset values. A fresh complete frame then commits with frame_count = 1. Additionally, 256 good frames wrap frame_count to 0.
